// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, issues pipelined in-order requests to a variable-latency
// instruction memory, buffers responses in a small FIFO and drives the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   pcf_q, pcf_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic          valid_q, valid_d;

  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, credit_ok, hs, resp_ok, push, pop;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_count == '0);
  // In-flight requests plus buffered entries never exceed DEPTH, so a push always has room.
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, fifo_count}) < DEPTH_W;

  assign imem_req_valid = !rst && !PCSrcE && credit_ok;
  assign imem_req_addr  = pcf_q;
  assign hs             = imem_req_valid && imem_req_ready;
  assign resp_ok        = imem_resp_valid && (outst_q != '0);
  assign push           = resp_ok && (drop_q == '0) && !PCSrcE;
  assign pop            = !PCSrcE && !FlushD && !StallD && !fifo_empty;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    pcf_d     = pcf_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q + CW'(hs) - CW'(resp_ok);
    drop_d    = drop_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcp4_d    = pcp4_q;
    valid_d   = valid_q;

    if (PCSrcE) begin
      pcf_d     = PCTargetE;
      resp_pc_d = PCTargetE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      // Everything still in flight after this cycle belongs to the abandoned path.
      drop_d    = outst_q - CW'(resp_ok);
    end else begin
      if (hs) pcf_d = pcf_q + 32'd4;
      if (resp_ok && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (FlushD || PCSrcE) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (!StallD) begin
      if (!fifo_empty) begin
        valid_d = 1'b1;
        instr_d = fifo_instr[rd_ptr_q[AW-1:0]];
        pcd_d   = fifo_pc[rd_ptr_q[AW-1:0]];
        pcp4_d  = fifo_pc[rd_ptr_q[AW-1:0]] + 32'd4;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q     <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      instr_q   <= NOP;
      pcd_q     <= '0;
      pcp4_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      pcf_q     <= pcf_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      instr_q   <= instr_d;
      pcd_q     <= pcd_d;
      pcp4_q    <= pcp4_d;
      valid_q   <= valid_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q[AW-1:0]]    <= resp_pc_q;
      fifo_instr[wr_ptr_q[AW-1:0]] <= imem_resp_data;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: in-order variable-latency memory model plus a transaction-level
// reference of the instruction stream seen by decode.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rst;
  logic        PCSrcE, StallD, FlushD;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int seq; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        mq[$];   // requests accepted by the memory, oldest first
  ent_t        eq[$];   // fetched instructions not yet handed to decode
  int          cyc, lat, next_seq, kill_seq;
  logic [31:0] m_next_pc, m_instr, m_pc, m_pcp4;
  logic        m_valid;
  int          passed, total;
  logic        last_req_valid;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    mq.delete();
    eq.delete();
    cyc       = 0;
    next_seq  = 0;
    kill_seq  = 0;
    m_next_pc = RESET_PC;
    m_valid   = 1'b0;
    m_instr   = NOP;
    m_pc      = '0;
    m_pcp4    = '0;
  endtask

  // One clock cycle: drive at the falling edge, check requests #1 later, advance the
  // reference at the rising edge and check the IF/ID outputs at the next falling edge.
  task automatic cycle(input logic stall, input logic flush, input logic pcsrc,
                       input logic [31:0] target, input logic ready);
    logic rv, exp_req;
    req_t r;
    ent_t head;
    StallD         = stall;
    FlushD         = flush;
    PCSrcE         = pcsrc;
    PCTargetE      = target;
    imem_req_ready = ready;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_valid = rv;
    imem_resp_data  = rv ? mem_word(mq[0].addr) : 32'h0;
    exp_req = !pcsrc && ((mq.size() + eq.size()) < DEPTH);
    #1;
    last_req_valid = imem_req_valid;
    last_req_addr  = imem_req_addr;
    total++;
    if (imem_req_valid !== exp_req)
      $display("FAIL req_valid cyc=%0d got %b exp %b", cyc, imem_req_valid, exp_req);
    else passed++;
    if (exp_req) begin
      total++;
      if (imem_req_addr !== m_next_pc)
        $display("FAIL req_addr cyc=%0d got %h exp %h", cyc, imem_req_addr, m_next_pc);
      else passed++;
    end
    @(posedge clk);
    if (flush || pcsrc) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!stall) begin
      if (eq.size() > 0) begin
        head    = eq.pop_front();
        m_valid = 1'b1;
        m_instr = head.instr;
        m_pc    = head.pc;
        m_pcp4  = head.pc + 32'd4;
      end else begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
    if (rv) begin
      r = mq.pop_front();
      if (r.seq >= kill_seq && !pcsrc) eq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
    end
    if (exp_req && ready) begin
      mq.push_back('{addr: m_next_pc, due: cyc + lat, seq: next_seq});
      next_seq++;
      m_next_pc = m_next_pc + 32'd4;
    end
    if (pcsrc) begin
      kill_seq  = next_seq;
      eq.delete();
      m_next_pc = target;
    end
    cyc++;
    @(negedge clk);
    total += 4;
    if (ValidD !== m_valid) $display("FAIL ValidD cyc=%0d got %b exp %b", cyc, ValidD, m_valid);
    else passed++;
    if (InstrD !== m_instr) $display("FAIL InstrD cyc=%0d got %h exp %h", cyc, InstrD, m_instr);
    else passed++;
    if (PCD !== m_pc) $display("FAIL PCD cyc=%0d got %h exp %h", cyc, PCD, m_pc);
    else passed++;
    if (PCPlus4D !== m_pcp4) $display("FAIL PCPlus4D cyc=%0d got %h exp %h", cyc, PCPlus4D, m_pcp4);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    @(negedge clk);
    @(negedge clk);
    total += 5;
    if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", imem_req_valid);
    else passed++;
    if (ValidD !== 1'b0) $display("FAIL reset_ValidD got %b exp 0", ValidD);
    else passed++;
    if (InstrD !== NOP) $display("FAIL reset_InstrD got %h exp %h", InstrD, NOP);
    else passed++;
    if (PCD !== 32'h0) $display("FAIL reset_PCD got %h exp 0", PCD);
    else passed++;
    if (PCPlus4D !== 32'h0) $display("FAIL reset_PCPlus4D got %h exp 0", PCPlus4D);
    else passed++;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    int first_valid, valid_cnt;
    logic [31:0] first_pc, first_pcp4;
    lat = 1;
    first_valid = -1;
    valid_cnt = 0;
    first_pc = '1;
    first_pcp4 = '1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, '0, 1);
      total++;
      if (!(last_req_valid === 1'b1 && last_req_addr === RESET_PC + 32'(4 * i)))
        $display("FAIL zw_req_seq i=%0d got %b/%h exp 1/%h", i, last_req_valid, last_req_addr,
                 RESET_PC + 32'(4 * i));
      else passed++;
      if (ValidD === 1'b1) begin
        valid_cnt++;
        if (first_valid < 0) begin
          first_valid = cyc;
          first_pc    = PCD;
          first_pcp4  = PCPlus4D;
        end
      end
    end
    total += 4;
    if (first_valid !== 3) $display("FAIL zw_first_valid_cycle got %0d exp 3", first_valid);
    else passed++;
    if (first_pc !== 32'h0) $display("FAIL zw_first_PCD got %h exp 0", first_pc);
    else passed++;
    if (first_pcp4 !== 32'h4) $display("FAIL zw_first_PCPlus4D got %h exp 4", first_pcp4);
    else passed++;
    if (valid_cnt !== 8) $display("FAIL zw_throughput got %0d exp 8", valid_cnt);
    else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_instr, exp_next;
    lat = 1;
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    held_pc    = m_pc;
    held_instr = mem_word(m_pc);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, '0, 1);
      total++;
      if (PCD !== held_pc || InstrD !== held_instr)
        $display("FAIL stall_frozen k=%0d got %h/%h exp %h/%h", k, PCD, InstrD, held_pc, held_instr);
      else passed++;
      if (k == 2) begin
        total++;
        if (last_req_valid !== 1'b0) $display("FAIL stall_full_req_valid got %b exp 0", last_req_valid);
        else passed++;
      end
    end
    exp_next = held_pc + 32'd4;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, '0, 1);
      total++;
      if (ValidD !== 1'b1 || PCD !== exp_next)
        $display("FAIL stall_resume k=%0d got %b/%h exp 1/%h", k, ValidD, PCD, exp_next);
      else passed++;
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic test_redirect();
    int n;
    lat = 3;
    n = 0;
    while ((mq.size() != 0 || eq.size() != 0) && n < 20) begin
      cycle(0, 0, 0, '0, 0);
      n++;
    end
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 1, 32'h100, 1);
    total++;
    if (ValidD !== 1'b0) $display("FAIL redir_bubble got %b exp 0", ValidD);
    else passed++;
    cycle(0, 0, 0, '0, 1);
    total++;
    if (last_req_valid !== 1'b1 || last_req_addr !== 32'h100)
      $display("FAIL redir_first_req got %b/%h exp 1/00000100", last_req_valid, last_req_addr);
    else passed++;
    n = 0;
    while (ValidD !== 1'b1 && n < 20) begin
      cycle(0, 0, 0, '0, 1);
      n++;
    end
    total++;
    if (ValidD !== 1'b1 || PCD !== 32'h100)
      $display("FAIL redir_first_PCD got %b/%h exp 1/00000100 (timeout or wrong pc)", ValidD, PCD);
    else passed++;
  endtask

  task automatic test_redirect_resp_stall();
    int n, stale;
    logic [31:0] first_pc;
    lat = 2;
    n = 0;
    while (!((mq.size() > 0) && (mq[0].due <= cyc) && m_valid) && n < 30) begin
      cycle(0, 0, 0, '0, 1);
      n++;
    end
    total++;
    if (n >= 30) $display("FAIL rrs_setup timeout got %0d exp <30", n);
    else passed++;
    cycle(1, 0, 1, 32'h200, 1);
    total++;
    if (ValidD !== 1'b0 || InstrD !== NOP)
      $display("FAIL rrs_flush_over_stall got %b/%h exp 0/%h", ValidD, InstrD, NOP);
    else passed++;
    stale = 0;
    first_pc = '1;
    for (int k = 0; k < 15; k++) begin
      cycle(0, 0, 0, '0, 1);
      if (ValidD === 1'b1) begin
        if (PCD < 32'h200) stale++;
        if (first_pc === 32'hFFFF_FFFF) first_pc = PCD;
      end
    end
    total += 2;
    if (stale !== 0) $display("FAIL rrs_stale_pc got %0d exp 0", stale);
    else passed++;
    if (first_pc !== 32'h200) $display("FAIL rrs_first_PCD got %h exp 00000200", first_pc);
    else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] exp_pc;
    lat = 1;
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, '0, 1);
    cycle(1, 0, 0, '0, 1);
    cycle(1, 0, 0, '0, 1);
    exp_pc = m_pc;
    cycle(0, 1, 0, '0, 1);
    total++;
    if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== exp_pc)
      $display("FAIL flush_bubble got %b/%h/%h exp 0/%h/%h", ValidD, InstrD, PCD, NOP, exp_pc);
    else passed++;
    cycle(0, 0, 0, '0, 1);
    total++;
    if (ValidD !== 1'b1 || PCD !== exp_pc + 32'd4 || InstrD !== mem_word(exp_pc + 32'd4))
      $display("FAIL flush_preserved got %b/%h exp 1/%h", ValidD, PCD, exp_pc + 32'd4);
    else passed++;
  endtask

  task automatic test_async_reset();
    lat = 1;
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, '0, 1);
    #2;
    rst = 1'b1;
    imem_resp_valid = 1'b0;
    #1;
    total += 5;
    if (imem_req_valid !== 1'b0) $display("FAIL areset_req_valid got %b exp 0", imem_req_valid);
    else passed++;
    if (ValidD !== 1'b0) $display("FAIL areset_ValidD got %b exp 0", ValidD);
    else passed++;
    if (InstrD !== NOP) $display("FAIL areset_InstrD got %h exp %h", InstrD, NOP);
    else passed++;
    if (PCD !== 32'h0) $display("FAIL areset_PCD got %h exp 0", PCD);
    else passed++;
    if (PCPlus4D !== 32'h0) $display("FAIL areset_PCPlus4D got %h exp 0", PCPlus4D);
    else passed++;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    cycle(0, 0, 0, '0, 1);
    total++;
    if (last_req_valid !== 1'b1 || last_req_addr !== RESET_PC)
      $display("FAIL areset_restart_req got %b/%h exp 1/%h", last_req_valid, last_req_addr, RESET_PC);
    else passed++;
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    total++;
    if (ValidD !== 1'b1 || PCD !== RESET_PC)
      $display("FAIL areset_restart_PCD got %b/%h exp 1/%h", ValidD, PCD, RESET_PC);
    else passed++;
  endtask

  task automatic test_random();
    logic st, fl, br, rd;
    logic [31:0] tgt;
    for (int k = 0; k < 400; k++) begin
      lat = int'($urandom_range(1, 4));
      st  = ($urandom % 5) == 0;
      fl  = ($urandom % 10) == 0;
      br  = ($urandom % 12) == 0;
      rd  = ($urandom % 4) != 0;
      tgt = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cycle(st, fl, br, tgt, rd);
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    lat    = 1;
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect();
    test_redirect_resp_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
